// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle CPU control FSM with retirement counter
//
// Sequences a multi-cycle core through IDLE, FETCH, DECODE, EXEC, MEM, WB
// and HALT, and decodes the datapath strobes from the current state and
// the latched opcode.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   imem_rdata      fetched instruction, opcode in bits [2:0]
//   imem_ack        instruction memory ready (rdata valid same cycle)
//   dmem_ack        data memory access complete
//   alu_zero        ALU result is zero (branch condition)
//   imem_req        instruction fetch request
//   dmem_req        data memory request, dmem_we marks a store
//   ir_we, pc_we    instruction register / PC write enables
//   reg_we          register file write enable
//   pc_src          0 = PC+2, 1 = PC+imm (branch), 2 = PC+imm (jump)
//   alu_src_imm     1 = immediate ALU operand, 0 = register
//   wb_sel          0 = ALU, 1 = memory data, 2 = PC (link)
//   state           current state encoding
//   halted          core stopped
//   retire_cnt      retired instruction count, wraps at 16 bits

module multi_cycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  pc_src,
    output logic        alu_src_imm,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic [15:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_R   = 3'b000;
    localparam logic [2:0] OP_I   = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_BEQ = 3'b100;
    localparam logic [2:0] OP_BNE = 3'b101;
    localparam logic [2:0] OP_J   = 3'b110;
    localparam logic [2:0] OP_JAL = 3'b111;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JMP  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  opcode_q;
    logic        halt_q;
    logic [15:0] retire_q;
    logic        fetch_done;
    logic        retire_inc;
    logic        br_taken;

    assign fetch_done = (state_q == S_FETCH) && imem_ack;

    // Branch condition: BEQ takes on zero, BNE on non-zero.
    assign br_taken = (opcode_q == OP_BEQ) ? alu_zero : !alu_zero;

    // An instruction retires whenever control returns to FETCH from one of
    // the completing states; DECODE never goes straight to FETCH.
    assign retire_inc = (state_d == S_FETCH) &&
                        ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= 3'd0;
            halt_q   <= 1'b0;
            retire_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (fetch_done) begin
                opcode_q <= imem_rdata[2:0];
                halt_q   <= (imem_rdata == 16'h0000);
            end
            if (retire_inc) begin
                retire_q <= retire_q + 16'd1;
            end
        end
    end

    // Next state and output decode. Everything defaults to 0 so a state
    // only lists the strobes it actually raises.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_we      = 1'b0;
        pc_src      = PC_INC;
        alu_src_imm = 1'b0;
        wb_sel      = WB_ALU;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = PC_INC;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = halt_q ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                case (opcode_q)
                    OP_R: begin
                        state_d = S_WB;
                    end
                    OP_I: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        if (br_taken) begin
                            pc_we  = 1'b1;
                            pc_src = PC_BR;
                        end
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_we   = 1'b1;
                        pc_src  = PC_JMP;
                        state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        // The PC was already advanced in FETCH, so the link
                        // value written here is the return address.
                        pc_we   = 1'b1;
                        pc_src  = PC_JMP;
                        reg_we  = 1'b1;
                        wb_sel  = WB_LINK;
                        state_d = S_FETCH;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode_q == OP_SW);
                if (dmem_ack) begin
                    state_d = (opcode_q == OP_SW) ? S_FETCH : S_WB;
                end
            end

            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (opcode_q == OP_LW) ? WB_MEM : WB_ALU;
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            // Unused encoding 7 recovers exactly like IDLE.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - randomized self-checking bench for multi_cycle_control

module tb_multi_cycle_control;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        dmem_ack;
    logic        alu_zero;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        pc_we;
    logic        reg_we;
    logic [1:0]  pc_src;
    logic        alu_src_imm;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        halted;
    logic [15:0] retire_cnt;

    logic [11:0] outs;
    int          n_vec;
    int          n_err;
    logic [15:0] exp_retire;

    multi_cycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .alu_zero    (alu_zero),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .reg_we      (reg_we),
        .pc_src      (pc_src),
        .alu_src_imm (alu_src_imm),
        .wb_sel      (wb_sel),
        .state       (state),
        .halted      (halted),
        .retire_cnt  (retire_cnt)
    );

    assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we,
                   pc_src, alu_src_imm, wb_sel, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] mk(input logic ir, input logic dr, input logic dw,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] ps, input logic ai,
                                       input logic [1:0] wb, input logic h);
        return {ir, dr, dw, irw, pcw, rw, ps, ai, wb, h};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Randomize every input the current cycle should not care about.
    task automatic rnd();
        imem_ack   = 1'($urandom);
        dmem_ack   = 1'($urandom);
        alu_zero   = 1'($urandom);
        imem_rdata = 16'($urandom);
    endtask

    // Check one cycle at the falling edge, then advance past the next rising edge.
    task automatic step(input logic [2:0] es, input logic [11:0] eo);
        @(negedge clk);
        check("state", 32'(state), 32'(es));
        check("outs", 32'(outs), 32'(eo));
        check("retire", 32'(retire_cnt), 32'(exp_retire));
        @(posedge clk);
        #1;
    endtask

    // Instruction-level reference: expected per-cycle trace of one
    // instruction, starting with the core sitting in FETCH.
    task automatic run_instr(input logic [15:0] instr, input int id, input int dd, input logic z);
        logic [2:0] op;
        logic       taken;
        op = instr[2:0];
        for (int i = 0; i < id; i++) begin
            rnd(); imem_ack = 1'b0;
            step(3'd1, mk(1,0,0,0,0,0,2'd0,0,2'd0,0));
        end
        rnd(); imem_ack = 1'b1; imem_rdata = instr;
        step(3'd1, mk(1,0,0,1,1,0,2'd0,0,2'd0,0));
        rnd();
        step(3'd2, 12'd0);
        if (instr == 16'h0000) return;
        rnd();
        case (op)
            3'd0, 3'd1: begin
                step(3'd3, mk(0,0,0,0,0,0,2'd0,op[0],2'd0,0));
                rnd();
                step(3'd5, mk(0,0,0,0,0,1,2'd0,0,2'd0,0));
            end
            3'd2, 3'd3: begin
                step(3'd3, mk(0,0,0,0,0,0,2'd0,1,2'd0,0));
                for (int i = 0; i <= dd; i++) begin
                    rnd(); dmem_ack = (i == dd);
                    step(3'd4, mk(0,1,op == 3'd3,0,0,0,2'd0,0,2'd0,0));
                end
                if (op == 3'd2) begin
                    rnd();
                    step(3'd5, mk(0,0,0,0,0,1,2'd0,0,2'd1,0));
                end
            end
            3'd4, 3'd5: begin
                alu_zero = z;
                taken = (op == 3'd4) ? z : !z;
                step(3'd3, mk(0,0,0,0,taken,0,taken ? 2'd1 : 2'd0,0,2'd0,0));
            end
            3'd6: step(3'd3, mk(0,0,0,0,1,0,2'd2,0,2'd0,0));
            default: step(3'd3, mk(0,0,0,0,1,1,2'd2,0,2'd2,0));
        endcase
        exp_retire = exp_retire + 16'd1;
    endtask

    initial begin
        logic [15:0] ins;
        n_vec      = 0;
        n_err      = 0;
        exp_retire = 16'd0;
        rst_n      = 1'b0;
        imem_rdata = 16'd0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        alu_zero   = 1'b0;

        // Reset state with inputs toggling.
        repeat (2) begin
            rnd();
            @(negedge clk);
            check("rst_state", 32'(state), 32'd0);
            check("rst_outs", 32'(outs), 32'd0);
            check("rst_retire", 32'(retire_cnt), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rnd();
        step(3'd0, 12'd0);

        // Directed instructions.
        run_instr(16'h1230, 0, 0, 1'b0);
        check("rtype_retire", 32'(retire_cnt), 32'd1);
        run_instr(16'h0012, 1, 3, 1'b0);
        run_instr(16'h0043, 0, 2, 1'b0);
        run_instr(16'h0004, 0, 0, 1'b1);
        run_instr(16'h0004, 0, 0, 1'b0);
        run_instr(16'h0005, 0, 0, 1'b1);
        run_instr(16'h0005, 2, 0, 1'b0);
        run_instr(16'h0007, 0, 0, 1'b0);
        run_instr(16'h0006, 0, 0, 1'b1);
        run_instr(16'h0101, 0, 0, 1'b0);

        // Random instruction stream.
        for (int k = 0; k < 300; k++) begin
            ins = 16'($urandom);
            if (ins == 16'h0000) ins = 16'h0001;
            run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                      1'($urandom));
        end

        // Reset during a MEM wait drops dmem_req immediately.
        rnd(); imem_ack = 1'b1; imem_rdata = 16'h0012;
        step(3'd1, mk(1,0,0,1,1,0,2'd0,0,2'd0,0));
        rnd();
        step(3'd2, 12'd0);
        rnd();
        step(3'd3, mk(0,0,0,0,0,0,2'd0,1,2'd0,0));
        rnd(); dmem_ack = 1'b0;
        step(3'd4, mk(0,1,0,0,0,0,2'd0,0,2'd0,0));
        dmem_ack = 1'b0;
        #2;
        check("mem_req_before_rst", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mem_rst_dmem_req", 32'(dmem_req), 32'd0);
        check("mem_rst_state", 32'(state), 32'd0);
        check("mem_rst_retire", 32'(retire_cnt), 32'd0);
        exp_retire = 16'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rnd();
        step(3'd0, 12'd0);

        // Retirement counter wrap.
        dut.retire_q = 16'hFFFF;
        exp_retire   = 16'hFFFF;
        run_instr(16'h0006, 0, 0, 1'b0);
        @(negedge clk);
        check("retire_wrap", 32'(retire_cnt), 32'd0);
        @(posedge clk); #1;

        // Halt instruction: terminal until reset.
        run_instr(16'h0000, 1, 0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            rnd();
            step(3'd6, mk(0,0,0,0,0,0,2'd0,0,2'd0,1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("halt_rst_state", 32'(state), 32'd0);
        check("halt_rst_outs", 32'(outs), 32'd0);
        exp_retire = 16'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rnd();
        step(3'd0, 12'd0);
        rnd(); imem_ack = 1'b0;
        step(3'd1, mk(1,0,0,0,0,0,2'd0,0,2'd0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
